seq_122333_checker: RTL and testbench
=====================================

Name: seq_122333_checker

Overview:
- Receive-side checker for the 1,2,2,3,3,3,... repeated-run counter stream: value N appears exactly N times, then N+1 follows.
- Samples a valid-qualified value stream, locks onto the pattern, reports each completed run, and flags and counts every deviation.
- Sits at the consumer end of the pattern-counter link; used in-system and as a self-checking monitor in benches.

Parameters:
- W, 6, width of the value bus; matches the 6-bit count of the generator.
- MAX_VAL, 63, last run value; after the run of MAX_VAL completes, the expected value wraps to 1 (MAX_VAL ≤ 2^W−1, ≥ 1).
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_value is a sample this cycle.
- in_value  input  W  sampled stream value.
- locked  output  1  checker is synchronised to the pattern.
- exp_value  output  W  value expected on the next valid sample (meaningful when locked).
- run_done  output  1  one-cycle pulse: a run completed correctly.
- run_value  output  W  value of the run just completed; held until the next run_done.
- error  output  1  one-cycle pulse: a valid sample violated the pattern while locked.
- err_count  output  ERR_W  number of errors; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): locked=0, exp_value=1, rep_cnt=0, run_done=0, run_value=0, error=0, err_count=0.
- Internal state: exp_value (W bits) and rep_cnt (W bits), the occurrences of exp_value seen so far in the current run.
- All outputs are registered; the response to a sample appears one cycle after the clk edge that accepts it.
- in_valid=0: no state change; run_done and error drop to 0.
- SEARCH state (locked=0): ignore every value except 1.
  - A value of 1 completes run 1 immediately: run_done=1, run_value=1, exp_value=2 (or 1 if MAX_VAL=1), rep_cnt=0, locked=1.
- LOCKED state, valid sample, in_value==exp_value:
  - If rep_cnt+1==exp_value: run_done=1, run_value=exp_value, rep_cnt=0, exp_value=(exp_value==MAX_VAL)?1:exp_value+1.
  - Otherwise: rep_cnt increments.
- LOCKED state, valid sample, in_value!=exp_value:
  - error=1, err_count+1 (saturating), rep_cnt=0.
  - If in_value==1: resynchronise in the same cycle. Apply the SEARCH handling for value 1, so error and run_done pulse together, run_value=1, exp_value=2, and locked stays 1.
  - Otherwise: locked=0, exp_value=1.
- Errors are never raised while locked=0.
- Wrap: run MAX_VAL completing sets exp_value=1. A following sample of 1 completes run 1 normally with no error.
- Gaps (in_valid low) inside a run are legal and do not reset rep_cnt.
- Reset mid-run: all state returns to reset values immediately; the checker then waits in SEARCH for a 1.
- err_count at all-ones stays all-ones; error still pulses.

Decomposition:
- Shared package seq_pat_pkg holds:
  - the state enum SEARCH/LOCKED;
  - default constants W=6 and MAX_VAL=63.
- The generator and checker both import this package.
- No sub-module is needed.
- The saturating counter is inline logic. It may optionally be factored into sat_counter if another block in the codebase needs one.

Test Plan:
- Reset, then valid stream 1,2,2,3,3,3,4,4,4,4 → run_done pulses with run_value 1,2,3,4; error never asserts; locked=1 from the cycle after the first 1; exp_value=5 at end.
- Stream 1,2,3 (third sample should be 2) → error pulse on 3, err_count=1, locked=0. Following 1,2,2 → relock; run_done for 1 and 2.
- Locked with exp_value=3 and rep_cnt=1, inject 1 → error and run_done pulse in the same cycle, run_value=1, exp_value=2, locked stays 1, err_count increments.
- MAX_VAL=3 instance, stream 1,2,2,3,3,3,1,2,2 → run_done after the third 3 with exp_value=1. The following 1 completes run 1 with no error.
- Stream 1,2,(in_valid low 5 cycles),2 with junk on in_value during the gap → run_done for 2 on the final sample; no error.
- ERR_W=2, drive 5 mismatches while locked (relocking via 1 each time) → err_count reaches 3 and stays; error pulses all 5 times. Assert rst_n low mid-run → all outputs go to reset values before the next clk edge.

Source files
------------

// File: rtl/seq_pat_pkg.sv
// Shared definitions for the repeated-run pattern link (1,2,2,3,3,3,...).
// Imported by both the pattern generator and the checker.
package seq_pat_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int DEF_W       = 6;
    localparam int DEF_MAX_VAL = 63;

endpackage : seq_pat_pkg

// File: rtl/seq_122333_checker.sv
// Receive-side checker for the repeated-run stream: value N appears N times, then N+1.
// Locks on a 1, reports each completed run, and flags and counts every deviation while locked.
module seq_122333_checker
    import seq_pat_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int ERR_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_value,
    output logic             locked,
    output logic [W-1:0]     exp_value,
    output logic             run_done,
    output logic [W-1:0]     run_value,
    output logic             error,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [W-1:0]     ONE       = W'(1);
    localparam logic [W-1:0]     MAX_V     = W'(MAX_VAL);
    // With a single-value pattern, run 1 is immediately followed by run 1 again.
    localparam logic [W-1:0]     AFTER_ONE = (MAX_VAL == 1) ? W'(1) : W'(2);
    localparam logic [ERR_W-1:0] ERR_SAT   = {ERR_W{1'b1}};

    state_e           state_q,     state_d;
    logic [W-1:0]     exp_value_q, exp_value_d;
    logic [W-1:0]     rep_cnt_q,   rep_cnt_d;
    logic             run_done_q,  run_done_d;
    logic [W-1:0]     run_value_q, run_value_d;
    logic             error_q,     error_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    // NOTE: every always_comb target gets a default first, so no path can leave one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        exp_value_d = exp_value_q;
        rep_cnt_d   = rep_cnt_q;
        run_done_d  = 1'b0;
        run_value_d = run_value_q;
        error_d     = 1'b0;
        err_count_d = err_count_q;

        if (in_valid) begin
            if (state_q == LOCKED && in_value == exp_value_q) begin
                if (rep_cnt_q + ONE == exp_value_q) begin
                    run_done_d  = 1'b1;
                    run_value_d = exp_value_q;
                    rep_cnt_d   = '0;
                    exp_value_d = (exp_value_q == MAX_V) ? ONE : exp_value_q + ONE;
                end else begin
                    rep_cnt_d = rep_cnt_q + ONE;
                end
            end else begin
                if (state_q == LOCKED) begin
                    error_d   = 1'b1;
                    rep_cnt_d = '0;
                    if (err_count_q != ERR_SAT) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    state_d     = SEARCH;
                    exp_value_d = ONE;
                end
                // A 1 always (re)starts the pattern: run 1 is complete on its single sample.
                if (in_value == ONE) begin
                    state_d     = LOCKED;
                    run_done_d  = 1'b1;
                    run_value_d = ONE;
                    exp_value_d = AFTER_ONE;
                    rep_cnt_d   = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            exp_value_q <= ONE;
            rep_cnt_q   <= '0;
            run_done_q  <= 1'b0;
            run_value_q <= '0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_value_q <= exp_value_d;
            rep_cnt_q   <= rep_cnt_d;
            run_done_q  <= run_done_d;
            run_value_q <= run_value_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = (state_q == LOCKED);
    assign exp_value = exp_value_q;
    assign run_done  = run_done_q;
    assign run_value = run_value_q;
    assign error     = error_q;
    assign err_count = err_count_q;

endmodule : seq_122333_checker

// File: tb/tb_seq_122333_checker.sv
// Directed bench for seq_122333_checker: default, MAX_VAL=3 and ERR_W=2 instances.
module tb_seq_122333_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [5:0] x0 = '0, x1 = '0, x2 = '0;

    logic       lk0, lk1, lk2, rd0, rd1, rd2, er0, er1, er2;
    logic [5:0] ev0, ev1, ev2, rv0, rv1, rv2;
    logic [7:0] ec0, ec1;
    logic [1:0] ec2;

    int errors = 0;
    int checks = 0;

    seq_122333_checker dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_value(x0),
        .locked(lk0), .exp_value(ev0), .run_done(rd0), .run_value(rv0),
        .error(er0), .err_count(ec0)
    );

    seq_122333_checker #(.MAX_VAL(3)) dut_m3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_value(x1),
        .locked(lk1), .exp_value(ev1), .run_done(rd1), .run_value(rv1),
        .error(er1), .err_count(ec1)
    );

    seq_122333_checker #(.ERR_W(2)) dut_e2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_value(x2),
        .locked(lk2), .exp_value(ev2), .run_done(rd2), .run_value(rv2),
        .error(er2), .err_count(ec2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic expect_out(input int d, input string tag, input logic e_lk, input logic [5:0] e_ev,
                              input logic e_rd, input logic [5:0] e_rv, input logic e_er,
                              input logic [7:0] e_ec);
        logic lk, rd, er;
        logic [5:0] ev, rv;
        logic [7:0] ec;
        case (d)
            0:       begin lk = lk0; ev = ev0; rd = rd0; rv = rv0; er = er0; ec = ec0; end
            1:       begin lk = lk1; ev = ev1; rd = rd1; rv = rv1; er = er1; ec = ec1; end
            default: begin lk = lk2; ev = ev2; rd = rd2; rv = rv2; er = er2; ec = {6'b0, ec2}; end
        endcase
        check({tag, ".locked"},    32'(lk), 32'(e_lk));
        check({tag, ".exp_value"}, 32'(ev), 32'(e_ev));
        check({tag, ".run_done"},  32'(rd), 32'(e_rd));
        check({tag, ".run_value"}, 32'(rv), 32'(e_rv));
        check({tag, ".error"},     32'(er), 32'(e_er));
        check({tag, ".err_count"}, 32'(ec), 32'(e_ec));
    endtask

    task automatic step(input int d, input logic v, input logic [5:0] x);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        case (d)
            0:       begin v0 = v; x0 = x; end
            1:       begin v1 = v; x1 = x; end
            default: begin v2 = v; x2 = x; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] t1_val [10] = '{1, 2, 2, 3, 3, 3, 4, 4, 4, 4};
        logic [5:0] t1_exp [10] = '{2, 2, 3, 3, 3, 4, 4, 4, 4, 5};
        logic       t1_rd  [10] = '{1, 0, 1, 0, 0, 1, 0, 0, 0, 1};
        logic [5:0] t1_rv  [10] = '{1, 1, 2, 2, 2, 3, 3, 3, 3, 4};
        logic [7:0] sat;

        do_reset();
        #1;
        expect_out(0, "reset_d0", 0, 1, 0, 0, 0, 0);
        expect_out(1, "reset_m3", 0, 1, 0, 0, 0, 0);
        expect_out(2, "reset_e2", 0, 1, 0, 0, 0, 0);

        // Clean stream 1,2,2,3,3,3,4,4,4,4
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, t1_val[i]);
            expect_out(0, $sformatf("clean[%0d]", i), 1, t1_exp[i], t1_rd[i], t1_rv[i], 0, 0);
        end

        // 1,2,3 -> error on 3, then relock with 1,2,2
        do_reset();
        step(0, 1'b1, 6'd1); expect_out(0, "bad_1",   1, 2, 1, 1, 0, 0);
        step(0, 1'b1, 6'd2); expect_out(0, "bad_2",   1, 2, 0, 1, 0, 0);
        step(0, 1'b1, 6'd3); expect_out(0, "bad_3",   0, 1, 0, 1, 1, 1);
        step(0, 1'b1, 6'd1); expect_out(0, "relock1", 1, 2, 1, 1, 0, 1);
        step(0, 1'b1, 6'd2); expect_out(0, "relock2", 1, 2, 0, 1, 0, 1);
        step(0, 1'b1, 6'd2); expect_out(0, "relock3", 1, 3, 1, 2, 0, 1);

        // exp=3, rep=1, then inject 1: error and run_done together
        step(0, 1'b1, 6'd3); expect_out(0, "resync_3", 1, 3, 0, 2, 0, 1);
        step(0, 1'b1, 6'd1); expect_out(0, "resync_1", 1, 2, 1, 1, 1, 2);

        // Gap of 5 invalid cycles with junk inside run 2
        do_reset();
        step(0, 1'b1, 6'd1); expect_out(0, "gap_1", 1, 2, 1, 1, 0, 0);
        step(0, 1'b1, 6'd2); expect_out(0, "gap_2", 1, 2, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1'b0, 6'(7 + 11 * i));
            expect_out(0, $sformatf("gap_idle[%0d]", i), 1, 2, 0, 1, 0, 0);
        end
        step(0, 1'b1, 6'd2); expect_out(0, "gap_end", 1, 3, 1, 2, 0, 0);

        // MAX_VAL=3 wrap
        step(1, 1'b1, 6'd1); expect_out(1, "wrap_1a", 1, 2, 1, 1, 0, 0);
        step(1, 1'b1, 6'd2); expect_out(1, "wrap_2a", 1, 2, 0, 1, 0, 0);
        step(1, 1'b1, 6'd2); expect_out(1, "wrap_2b", 1, 3, 1, 2, 0, 0);
        step(1, 1'b1, 6'd3); expect_out(1, "wrap_3a", 1, 3, 0, 2, 0, 0);
        step(1, 1'b1, 6'd3); expect_out(1, "wrap_3b", 1, 3, 0, 2, 0, 0);
        step(1, 1'b1, 6'd3); expect_out(1, "wrap_3c", 1, 1, 1, 3, 0, 0);
        step(1, 1'b1, 6'd1); expect_out(1, "wrap_1b", 1, 2, 1, 1, 0, 0);
        step(1, 1'b1, 6'd2); expect_out(1, "wrap_2c", 1, 2, 0, 1, 0, 0);
        step(1, 1'b1, 6'd2); expect_out(1, "wrap_2d", 1, 3, 1, 2, 0, 0);

        // ERR_W=2 saturation over 5 mismatches
        step(2, 1'b1, 6'd1); expect_out(2, "sat_lock", 1, 2, 1, 1, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            sat = (i > 3) ? 8'd3 : 8'(i);
            step(2, 1'b1, 6'd3);
            expect_out(2, $sformatf("sat_err[%0d]", i), 0, 1, 0, 1, 1, sat);
            step(2, 1'b1, 6'd1);
            expect_out(2, $sformatf("sat_relock[%0d]", i), 1, 2, 1, 1, 0, sat);
        end

        // Asynchronous reset mid-run
        do_reset();
        step(0, 1'b1, 6'd1);
        step(0, 1'b1, 6'd2);
        step(0, 1'b1, 6'd2);
        step(0, 1'b1, 6'd3); expect_out(0, "pre_rst", 1, 3, 0, 2, 0, 0);
        @(negedge clk);
        v0 = 1'b0;
        rst_n = 1'b0;
        #1;
        expect_out(0, "async_rst", 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1'b1, 6'd2); expect_out(0, "post_rst_ignore", 0, 1, 0, 0, 0, 0);
        step(0, 1'b1, 6'd1); expect_out(0, "post_rst_lock",   1, 2, 1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_122333_checker
